// File: rtl/ramp_cmd_producer.sv
// Host-side command producer for the ramp generator: converts signed step requests
// to sign/magnitude, buffers them in a FIFO and hands them on over a 4-phase link.
// Optional drop/near-full counter enabled by defining DROP_CNT_EN.
module ramp_cmd_producer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clock,
    input  logic          reset_,
    input  logic [7:0]    x,
    input  logic          dav_in_,
    output logic          rfd_in,
    output logic          s,
    output logic [6:0]    h,
    output logic          dav_,
    input  logic          rfd,
`ifdef DROP_CNT_EN
    output logic [7:0]    drops,
`endif
    output logic [AW:0]   level
);

    localparam int unsigned EW   = 8;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        IN_I0,
        IN_I1
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_O0,
        OUT_O1,
        OUT_O2
    } out_state_t;

    in_state_t     in_state;
    in_state_t     in_next;
    out_state_t    out_state;
    out_state_t    out_next;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          conv_s;
    logic [6:0]    conv_h;
    logic          accept;
    logic          push;
    logic          load;
    logic          pop;
    logic [AW:0]   level_next;
    logic          rfd_in_next;
    logic          dav_next;

    // Sign/magnitude conversion; -128 has no 7-bit magnitude and saturates to 127.
    always_comb begin
        conv_s = x[7];
        conv_h = x[6:0];
        if (x[7]) begin
            if (x[6:0] == 7'h00) begin
                conv_h = 7'h7F;
            end else begin
                conv_h = 7'(~x[6:0] + 7'd1);
            end
        end
    end

    // Host-side handshake: accept one request per dav_in_ low phase.
    always_comb begin
        in_next = in_state;
        accept  = 1'b0;
        push    = 1'b0;
        case (in_state)
            IN_I0: begin
                if (!dav_in_ && (level != FULL)) begin
                    accept  = 1'b1;
                    push    = (x != 8'h00);
                    in_next = IN_I1;
                end
            end
            IN_I1: begin
                if (dav_in_) begin
                    in_next = IN_I0;
                end
            end
            default: in_next = IN_I0;
        endcase
    end

    // Ramp-side handshake: head is popped only once the ramp stage acknowledges.
    always_comb begin
        out_next = out_state;
        load     = 1'b0;
        pop      = 1'b0;
        case (out_state)
            OUT_O0: begin
                if ((level != '0) && rfd) begin
                    load     = 1'b1;
                    out_next = OUT_O1;
                end
            end
            OUT_O1: begin
                if (!rfd) begin
                    pop      = 1'b1;
                    out_next = OUT_O2;
                end
            end
            OUT_O2: begin
                if (rfd) begin
                    out_next = OUT_O0;
                end
            end
            default: out_next = OUT_O0;
        endcase
    end

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + (AW+1)'(1);
            2'b01:   level_next = level - (AW+1)'(1);
            default: level_next = level;
        endcase
        rfd_in_next = (in_next == IN_I0) && (level_next != FULL);
        dav_next    = (out_next != OUT_O1);
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            in_state  <= IN_I0;
            out_state <= OUT_O0;
            rfd_in    <= 1'b1;
            dav_      <= 1'b1;
            s         <= 1'b0;
            h         <= 7'h00;
            level     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            in_state  <= in_next;
            out_state <= out_next;
            rfd_in    <= rfd_in_next;
            dav_      <= dav_next;
            level     <= level_next;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (load) begin
                {s, h} <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= {conv_s, conv_h};
        end
    end

`ifdef DROP_CNT_EN
    localparam logic [AW:0] ALMOST = (AW+1)'(DEPTH - 1);

    logic drop_hit;

    // Counts dropped zero requests and pushes that leave the FIFO full.
    assign drop_hit = accept && ((x == 8'h00) || ((level == ALMOST) && !pop));

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            drops <= 8'h00;
        end else if (drop_hit && (drops != 8'hFF)) begin
            drops <= drops + 8'd1;
        end
    end
`endif

endmodule
